// File: rtl/pulse_list_loader.sv
// Pulse-list loader: deserialises PC message words into per-ZMW pulse records and
// writes them into two ping-pong BRAM banks, tracking bank ownership with the consumer.
module pulse_list_loader #(
    parameter int unsigned DELAY          = 1,
    parameter int unsigned XB_SIZE        = 32,
    parameter int unsigned DRAM_DATA_SIZE = 256,
    parameter int unsigned N_ZMW          = 128
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       pc_msg_valid,
    input  logic [XB_SIZE-1:0]         pc_msg,
    output logic                       pc_msg_ack,
    output logic [1:0]                 wr_en,
    output logic [$clog2(N_ZMW)-1:0]   wr_addr,
    output logic [DRAM_DATA_SIZE-1:0]  wr_data,
    output logic [1:0]                 bank_full,
    input  logic [1:0]                 bank_release,
    output logic                       load_bank,
    output logic [15:0]                frames_loaded,
    output logic                       error,
    output logic [1:0]                 state_o
);

    localparam int unsigned WPE        = DRAM_DATA_SIZE / XB_SIZE;
    localparam int unsigned AW         = $clog2(N_ZMW);
    localparam int unsigned WCW        = (WPE > 1) ? $clog2(WPE) : 1;
    localparam logic [7:0]  HDR_OPCODE = 8'h5A;

    // DELAY only shapes timing in delay-annotated simulation; this RTL is zero-delay,
    // so it is merely range-checked alongside the structural parameters.
    if ((DRAM_DATA_SIZE % XB_SIZE) != 0 || WPE < 2 || N_ZMW < 2 ||
        (N_ZMW & (N_ZMW - 1)) != 0 || XB_SIZE < 8 || DELAY > 1000) begin : g_param_check
        $error("pulse_list_loader: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_HDR       = 2'd0,
        ST_WAIT_BANK = 2'd1,
        ST_LOAD      = 2'd2,
        ST_ERROR     = 2'd3
    } state_t;

    state_t                    state, state_n;
    logic                      ack_n;
    logic [WCW-1:0]            word_cnt, word_cnt_n;
    logic [AW-1:0]             zmw_cnt, zmw_cnt_n;
    logic [DRAM_DATA_SIZE-1:0] rec_buf, rec_buf_n;
    logic                      rec_pending, rec_pending_n;
    logic [1:0]                wr_en_n;
    logic [AW-1:0]             wr_addr_n;
    logic [DRAM_DATA_SIZE-1:0] wr_data_n;
    logic [1:0]                bank_full_n, bank_set;
    logic                      load_bank_n;
    logic [15:0]               frames_n;
    logic                      error_n;
    logic                      take;
    logic                      hdr_ok;

    // A presented word may be taken only while no ack is outstanding for it.
    assign take    = pc_msg_valid && !pc_msg_ack;
    assign hdr_ok  = (pc_msg[XB_SIZE-1 -: 8] == HDR_OPCODE);
    assign state_o = state;

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= ST_HDR;
            pc_msg_ack    <= 1'b0;
            word_cnt      <= '0;
            zmw_cnt       <= '0;
            rec_buf       <= '0;
            rec_pending   <= 1'b0;
            wr_en         <= '0;
            wr_addr       <= '0;
            wr_data       <= '0;
            bank_full     <= '0;
            load_bank     <= 1'b0;
            frames_loaded <= '0;
            error         <= 1'b0;
        end else begin
            state         <= state_n;
            pc_msg_ack    <= ack_n;
            word_cnt      <= word_cnt_n;
            zmw_cnt       <= zmw_cnt_n;
            rec_buf       <= rec_buf_n;
            rec_pending   <= rec_pending_n;
            wr_en         <= wr_en_n;
            wr_addr       <= wr_addr_n;
            wr_data       <= wr_data_n;
            bank_full     <= bank_full_n;
            load_bank     <= load_bank_n;
            frames_loaded <= frames_n;
            error         <= error_n;
        end
    end

    // Next-state, handshake, record assembly and bank bookkeeping.
    always_comb begin
        state_n       = state;
        ack_n         = 1'b0;
        word_cnt_n    = word_cnt;
        zmw_cnt_n     = zmw_cnt;
        rec_buf_n     = rec_buf;
        rec_pending_n = 1'b0;
        wr_en_n       = '0;
        wr_addr_n     = wr_addr;
        wr_data_n     = wr_data;
        load_bank_n   = load_bank;
        frames_n      = frames_loaded;
        bank_set      = '0;

        unique case (state)
            ST_HDR: begin
                if (take) begin
                    if (hdr_ok) begin
                        ack_n = 1'b1;
                        // A release arriving with the header frees the bank immediately.
                        if (bank_full[load_bank] && !bank_release[load_bank]) begin
                            state_n = ST_WAIT_BANK;
                        end else begin
                            state_n = ST_LOAD;
                        end
                    end else begin
                        state_n = ST_ERROR;
                    end
                end
            end

            ST_WAIT_BANK: begin
                if (bank_release[load_bank] || !bank_full[load_bank]) begin
                    state_n = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (rec_pending) begin
                    wr_en_n[load_bank] = 1'b1;
                    wr_addr_n          = zmw_cnt;
                    wr_data_n          = rec_buf;
                    if (zmw_cnt == AW'(N_ZMW - 1)) begin
                        zmw_cnt_n           = '0;
                        bank_set[load_bank] = 1'b1;
                        load_bank_n         = ~load_bank;
                        frames_n            = frames_loaded + 16'd1;
                        state_n             = ST_HDR;
                    end else begin
                        zmw_cnt_n = zmw_cnt + AW'(1);
                    end
                end else if (take) begin
                    ack_n     = 1'b1;
                    // LS word first: shifting right leaves word 0 at the bottom.
                    rec_buf_n = {pc_msg, rec_buf[DRAM_DATA_SIZE-1:XB_SIZE]};
                    if (word_cnt == WCW'(WPE - 1)) begin
                        word_cnt_n    = '0;
                        rec_pending_n = 1'b1;
                    end else begin
                        word_cnt_n = word_cnt + WCW'(1);
                    end
                end
            end

            ST_ERROR: begin
                state_n = ST_ERROR;
            end

            default: begin
                state_n = ST_ERROR;
            end
        endcase

        // Set wins over a same-bank release; releases of idle banks are no-ops.
        bank_full_n = (bank_full & ~bank_release) | bank_set;
        error_n     = (state_n == ST_ERROR);
    end

endmodule

// File: tb/tb_pulse_list_loader.sv
// Scoreboard bench for pulse_list_loader: randomized frames against a frame-level model,
// with a decoupled monitor checking every BRAM write and ack spacing.
module tb_pulse_list_loader;

    localparam int unsigned XB  = 32;
    localparam int unsigned DW  = 256;
    localparam int unsigned NZ  = 4;
    localparam int unsigned WPE = DW / XB;
    localparam int unsigned AW  = 2;

    logic           CLK = 1'b0;
    logic           RESET_N = 1'b0;
    logic           pc_msg_valid = 1'b0;
    logic [XB-1:0]  pc_msg = '0;
    logic           pc_msg_ack;
    logic [1:0]     wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [1:0]     bank_full;
    logic [1:0]     bank_release = 2'b00;
    logic           load_bank;
    logic [15:0]    frames_loaded;
    logic           error;
    logic [1:0]     state_o;

    pulse_list_loader #(
        .DELAY(1), .XB_SIZE(XB), .DRAM_DATA_SIZE(DW), .N_ZMW(NZ)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .pc_msg_valid(pc_msg_valid), .pc_msg(pc_msg), .pc_msg_ack(pc_msg_ack),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bank_full(bank_full), .bank_release(bank_release),
        .load_bank(load_bank), .frames_loaded(frames_loaded),
        .error(error), .state_o(state_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         got;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ack_count = 0;
    int          last_ack = -100;

    // Frame-level reference state
    logic [1:0]  m_bf = 2'b00;
    logic        m_lb = 1'b0;
    logic [15:0] m_frames = 16'd0;
    int          m_zmw = 0;
    int          m_wcnt = 0;
    logic [DW-1:0] m_rec = '0;
    logic [XB-1:0] fw[32];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Monitor: ack spacing and write scoreboard.
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (pc_msg_ack) begin
                ack_count++;
                check("ack_spacing", 256'(cyc - last_ack >= 2), 256'd1);
                last_ack = cyc;
            end
            if (wr_en != 2'b00) begin
                check("wr_onehot", 256'($onehot(wr_en)), 256'd1);
                if (sb.size() == 0) begin
                    check("wr_unexpected", 256'(wr_en), 256'd0);
                end else begin
                    got = sb.pop_front();
                    check("wr_bank", 256'(wr_en), 256'(2'b01 << got.bank));
                    check("wr_addr", 256'(wr_addr), 256'(got.addr));
                    check("wr_data", wr_data, got.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic present(input logic [XB-1:0] w);
        pc_msg       = w;
        pc_msg_valid = 1'b1;
    endtask

    task automatic wait_ack(input string name, input logic [1:0] rel, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            @(negedge CLK);
            if (pc_msg_ack) ok = 1'b1;
            else n++;
        end
        check({name, "_ack_timeout"}, 256'(ok), 256'd1);
        if (ok && rel != 2'b00) bank_release = rel;
        @(posedge CLK);
        #1;
        bank_release = 2'b00;
        pc_msg_valid = 1'b0;
    endtask

    // Model: a word is accepted; every WPE words form one record for the current bank.
    task automatic model_data(input logic [XB-1:0] w, input logic [1:0] rel);
        m_bf &= ~rel;
        m_rec[m_wcnt*XB +: XB] = w;
        if (m_wcnt == WPE - 1) begin
            sb.push_back('{m_lb, AW'(m_zmw), m_rec});
            m_wcnt = 0;
            m_zmw++;
            if (m_zmw == NZ) begin
                m_zmw = 0;
                m_bf[m_lb] = 1'b1;
                m_lb = ~m_lb;
                m_frames++;
            end
        end else begin
            m_wcnt++;
        end
    endtask

    task automatic send_data(input logic [XB-1:0] w, input logic [1:0] rel, input int gap);
        bit ok;
        present(w);
        wait_ack("data", rel, ok);
        if (ok) model_data(w, rel);
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_hdr(input logic [XB-1:0] h);
        bit ok;
        present(h);
        wait_ack("hdr", 2'b00, ok);
        check("hdr_state", 256'(state_o), m_bf[m_lb] ? 256'd1 : 256'd2);
    endtask

    task automatic send_frame(input int gap_max, input logic [1:0] last_rel);
        send_hdr({8'h5A, 24'($urandom)});
        for (int i = 0; i < 32; i++) begin
            send_data(fw[i], (i == 31) ? last_rel : 2'b00, $urandom_range(0, gap_max));
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) fw[i] = $urandom;
    endtask

    task automatic pulse_release(input logic [1:0] r);
        @(negedge CLK);
        bank_release = r;
        @(negedge CLK);
        bank_release = 2'b00;
        m_bf &= ~r;
    endtask

    task automatic check_status(input string name);
        repeat (2) @(negedge CLK);
        check({name, "_bank_full"}, 256'(bank_full), 256'(m_bf));
        check({name, "_load_bank"}, 256'(load_bank), 256'(m_lb));
        check({name, "_frames"}, 256'(frames_loaded), 256'(m_frames));
        check({name, "_state"}, 256'(state_o), 256'd0);
        check({name, "_error"}, 256'(error), 256'd0);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_wr_data"}, wr_data, 256'd0);
        check({name, "_outs"},
              256'({pc_msg_ack, wr_en, wr_addr, bank_full, load_bank, frames_loaded, error, state_o}),
              256'd0);
    endtask

    task automatic reset_dut(input string name);
        @(negedge CLK);
        RESET_N      = 1'b0;
        pc_msg_valid = 1'b0;
        #1;
        check_zero_outputs(name);
        check({name, "_sb_drained"}, 256'(sb.size()), 256'd0);
        @(negedge CLK);
        RESET_N  = 1'b1;
        m_bf     = 2'b00;
        m_lb     = 1'b0;
        m_frames = 16'd0;
        m_zmw    = 0;
        m_wcnt   = 0;
        sb.delete();
    endtask

    initial begin
        int a0;
        bit ok;

        repeat (2) @(negedge CLK);
        check_zero_outputs("reset");
        RESET_N = 1'b1;
        @(negedge CLK);

        // Frame 1: data words 0..31, valid held continuously
        for (int i = 0; i < 32; i++) fw[i] = 32'(i);
        send_frame(0, 2'b00);
        check_status("f1");

        // Frame 2 fills bank 1
        fill_random();
        send_frame(2, 2'b00);
        check_status("f2");

        // Frame 3: both banks owned downstream, header parks in WAIT_BANK
        fill_random();
        send_hdr(32'h5A0000AB);
        present(fw[0]);
        a0 = ack_count;
        repeat (50) @(negedge CLK);
        check("wait_no_ack", 256'(ack_count), 256'(a0));
        check("wait_state", 256'(state_o), 256'd1);
        bank_release = 2'b01;
        @(negedge CLK);
        bank_release = 2'b00;
        m_bf[0] = 1'b0;
        wait_ack("wait_resume", 2'b00, ok);
        if (ok) model_data(fw[0], 2'b00);
        for (int i = 1; i < 32; i++) send_data(fw[i], 2'b00, $urandom_range(0, 2));
        check_status("f3");

        // Frame 4 into bank 1
        pulse_release(2'b10);
        fill_random();
        send_frame(2, 2'b00);
        check_status("f4");

        // Frame 5 into bank 0, releasing bank 1 on the completing write
        pulse_release(2'b01);
        fill_random();
        send_frame(1, 2'b10);
        check_status("f5");

        // Frame 6 goes straight to LOAD in bank 1
        fill_random();
        send_frame(2, 2'b00);
        check_status("f6");

        // Frame 7 wraps the frame counter
        pulse_release(2'b01);
        @(negedge CLK);
        force dut.frames_loaded = 16'hFFFF;
        #1;
        release dut.frames_loaded;
        m_frames = 16'hFFFF;
        fill_random();
        send_frame(1, 2'b00);
        check_status("f7_wrap");

        // Partial frame interrupted by reset
        pulse_release(2'b10);
        fill_random();
        send_hdr(32'h5A123456);
        for (int i = 0; i < 10; i++) send_data(fw[i], 2'b00, $urandom_range(0, 1));
        reset_dut("midload");

        // Fresh frame after reset lands in bank 0 from address 0
        fill_random();
        send_frame(2, 2'b00);
        check_status("f8");

        // Bad header locks into ERROR until reset
        present(32'h12345678);
        a0 = ack_count;
        repeat (20) @(negedge CLK);
        check("bad_no_ack", 256'(ack_count), 256'(a0));
        check("bad_error", 256'(error), 256'd1);
        check("bad_state", 256'(state_o), 256'd3);
        present(32'h5A000000);
        repeat (20) @(negedge CLK);
        check("err_no_ack", 256'(ack_count), 256'(a0));
        check("err_state", 256'(state_o), 256'd3);
        reset_dut("err_reset");
        @(negedge CLK);
        check("post_err_state", 256'(state_o), 256'd0);
        check("post_err_error", 256'(error), 256'd0);

        check("sb_empty", 256'(sb.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
